// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the PC sequencer and the decode/fetch stages.
// Optional feature macro: PC_BRANCH_STATS_EN adds the taken_count signal.
interface pc_sequencer_if;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_dec;
  logic        imem_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_req;
  logic        ifid_we;
  logic        ifid_flush;
  logic        halted;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_count;
`endif

  // Sequencer side: consumes hazard/branch/memory status, drives PC and IF/ID controls.
  modport master (
    input  stall,
    input  br_valid,
    input  br_taken,
    input  br_target,
    input  halt_dec,
    input  imem_ready,
    output pc,
    output pc_plus2,
    output fetch_req,
    output ifid_we,
    output ifid_flush,
    output halted
`ifdef PC_BRANCH_STATS_EN
    , output taken_count
`endif
  );

  // Pipeline side: the mirror view.
  modport slave (
    output stall,
    output br_valid,
    output br_taken,
    output br_target,
    output halt_dec,
    output imem_ready,
    input  pc,
    input  pc_plus2,
    input  fetch_req,
    input  ifid_we,
    input  ifid_flush,
    input  halted
`ifdef PC_BRANCH_STATS_EN
    , input taken_count
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: sequential advance, hold on hazard/memory wait,
// redirect to decode-resolved branch targets, drain of the in-flight fetch after
// a redirect, and a terminal HALT state left only through reset.
// Optional feature macro: PC_BRANCH_STATS_EN adds a saturating taken-redirect counter.
module pc_sequencer (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [15:0] r_pc;
  logic [15:0] w_pc_d;
  logic [15:0] w_pc_plus2;
  logic        w_fetch_req;
  logic        w_ifid_we;
  logic        w_ifid_flush;
  logic        w_taken_acc;

  assign w_pc_plus2 = r_pc + 16'd2;

  // State and PC register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StRun;
      r_pc    <= 16'h0000;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
    end
  end

  // Next-state, next-PC and fetch/IF-ID controls.
  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_fetch_req  = 1'b0;
    w_ifid_we    = 1'b0;
    w_ifid_flush = 1'b0;
    w_taken_acc  = 1'b0;
    unique case (r_state)
      StRun: begin
        w_fetch_req = 1'b1;
        if (bus.stall) begin
          // Hold everything; branch/halt are re-evaluated once the stall clears.
        end else if (bus.halt_dec) begin
          w_ifid_flush = 1'b1;
          w_state_d    = StHalt;
        end else if (bus.br_valid && bus.br_taken) begin
          w_pc_d       = {bus.br_target[15:1], 1'b0};
          w_ifid_flush = 1'b1;
          w_taken_acc  = 1'b1;
          // A fetch still outstanding belongs to the wrong path and must be dropped.
          w_state_d    = bus.imem_ready ? StRun : StDrain;
        end else if (bus.imem_ready) begin
          w_pc_d    = w_pc_plus2;
          w_ifid_we = 1'b1;
        end else begin
          w_ifid_flush = 1'b1;
        end
      end
      StDrain: begin
        w_ifid_flush = 1'b1;
        if (bus.imem_ready) begin
          w_state_d = StRun;
        end
      end
      StHalt: begin
        w_ifid_flush = 1'b1;
      end
      default: begin
        w_state_d = StRun;
      end
    endcase
  end

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] r_taken_count;

  // Saturating count of accepted taken redirects.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taken_count <= 16'h0000;
    end else if (w_taken_acc && (r_taken_count != 16'hFFFF)) begin
      r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign bus.taken_count = r_taken_count;
`else
  logic w_unused_taken_acc;
  assign w_unused_taken_acc = w_taken_acc;
`endif

  assign bus.pc         = r_pc;
  assign bus.pc_plus2   = w_pc_plus2;
  assign bus.fetch_req  = w_fetch_req;
  assign bus.ifid_we    = w_ifid_we;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.halted     = (r_state == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirect with and without
// drain, stalled branch, wraparound, halt and reset recovery. Counter checks are
// compiled in only when PC_BRANCH_STATS_EN is defined.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pc_sequencer_if u_bus ();

  pc_sequencer u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic stall, input logic bv, input logic bt,
                        input logic [15:0] tgt, input logic hlt, input logic rdy);
    u_bus.stall      = stall;
    u_bus.br_valid   = bv;
    u_bus.br_taken   = bt;
    u_bus.br_target  = tgt;
    u_bus.halt_dec   = hlt;
    u_bus.imem_ready = rdy;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset values.
    chk("rst_pc", u_bus.pc, 16'h0000);
    chk("rst_pc_plus2", u_bus.pc_plus2, 16'h0002);
    chk("rst_fetch_req", u_bus.fetch_req, 16'h1);
    chk("rst_ifid_we", u_bus.ifid_we, 16'h0);
    chk("rst_ifid_flush", u_bus.ifid_flush, 16'h1);
    chk("rst_halted", u_bus.halted, 16'h0);
`ifdef PC_BRANCH_STATS_EN
    chk("rst_taken_count", u_bus.taken_count, 16'h0000);
`endif

    // Release reset, sequential fetch with imem_ready held high.
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("seq_we0", u_bus.ifid_we, 16'h1);
    tick();
    chk("seq_pc1", u_bus.pc, 16'h0002);
    chk("seq_we1", u_bus.ifid_we, 16'h1);
    tick();
    chk("seq_pc2", u_bus.pc, 16'h0004);
    for (int i = 0; i < 6; i++) tick();
    chk("seq_pc_10", u_bus.pc, 16'h0010);

    // Taken branch with memory ready: redirect, stay in RUN.
    set_in(1'b0, 1'b1, 1'b1, 16'h0041, 1'b0, 1'b1);
    chk("br_flush", u_bus.ifid_flush, 16'h1);
    chk("br_we", u_bus.ifid_we, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("br_pc", u_bus.pc, 16'h0040);
    chk("br_run_fetch", u_bus.fetch_req, 16'h1);
`ifdef PC_BRANCH_STATS_EN
    chk("br_count1", u_bus.taken_count, 16'h0001);
`endif

    // Taken branch with memory busy: drain the stale fetch.
    set_in(1'b0, 1'b1, 1'b1, 16'h0041, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("drn_pc", u_bus.pc, 16'h0040);
    chk("drn_fetch", u_bus.fetch_req, 16'h0);
    chk("drn_flush", u_bus.ifid_flush, 16'h1);
    // Branch in DRAIN must be ignored.
    set_in(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    chk("drn_ignore_br_pc", u_bus.pc, 16'h0040);
    chk("drn_fetch2", u_bus.fetch_req, 16'h0);
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("drn_drop_we", u_bus.ifid_we, 16'h0);
    chk("drn_drop_flush", u_bus.ifid_flush, 16'h1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("drn_exit_fetch", u_bus.fetch_req, 16'h1);
    chk("drn_exit_pc", u_bus.pc, 16'h0040);
`ifdef PC_BRANCH_STATS_EN
    chk("drn_count2", u_bus.taken_count, 16'h0002);
`endif

    // Stalled taken branch: hold two cycles, redirect on the third.
    set_in(1'b1, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b1);
    chk("stl_flush", u_bus.ifid_flush, 16'h0);
    chk("stl_we", u_bus.ifid_we, 16'h0);
    tick();
    chk("stl_pc1", u_bus.pc, 16'h0040);
    tick();
    chk("stl_pc2", u_bus.pc, 16'h0040);
    set_in(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b1);
    chk("stl_rel_flush", u_bus.ifid_flush, 16'h1);
    tick();
    chk("stl_redirect_pc", u_bus.pc, 16'h0200);
`ifdef PC_BRANCH_STATS_EN
    chk("stl_count3", u_bus.taken_count, 16'h0003);
`endif

    // Odd target 0xFFFF lands on 0xFFFE; then wrap to 0x0000.
    set_in(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("wrap_pc_fffe", u_bus.pc, 16'hFFFE);
    chk("wrap_plus2", u_bus.pc_plus2, 16'h0000);
    tick();
    chk("wrap_pc_0", u_bus.pc, 16'h0000);
    // Bubble: not-taken branch but memory not ready.
    set_in(1'b0, 1'b1, 1'b0, 16'h0800, 1'b0, 1'b0);
    chk("bub_flush", u_bus.ifid_flush, 16'h1);
    chk("bub_we", u_bus.ifid_we, 16'h0);
    tick();
    chk("bub_pc", u_bus.pc, 16'h0000);
    // Not-taken branch with memory ready is sequential.
    set_in(1'b0, 1'b1, 1'b0, 16'h0800, 1'b0, 1'b1);
    chk("nt_we", u_bus.ifid_we, 16'h1);
    tick();
    chk("nt_pc", u_bus.pc, 16'h0002);

    // Halt, then ignore branches for 10 cycles.
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("hlt_flush", u_bus.ifid_flush, 16'h1);
    tick();
    chk("hlt_halted", u_bus.halted, 16'h1);
    chk("hlt_fetch", u_bus.fetch_req, 16'h0);
    set_in(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("hlt_pc_frozen", u_bus.pc, 16'h0002);
    chk("hlt_still", u_bus.halted, 16'h1);
    chk("hlt_flush2", u_bus.ifid_flush, 16'h1);
`ifdef PC_BRANCH_STATS_EN
    chk("hlt_count", u_bus.taken_count, 16'h0004);
`endif

    // Asynchronous reset out of HALT.
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst2_pc", u_bus.pc, 16'h0000);
    chk("rst2_halted", u_bus.halted, 16'h0);
    chk("rst2_fetch", u_bus.fetch_req, 16'h1);
`ifdef PC_BRANCH_STATS_EN
    chk("rst2_count", u_bus.taken_count, 16'h0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PC_BRANCH_STATS_EN
    // Saturation: 65537 accepted redirects.
    set_in(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1);
    for (int i = 0; i < 65537; i++) tick();
    chk("sat_count", u_bus.taken_count, 16'hFFFF);
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
